// File: rtl/cola_vend_arb_pkg.sv
// Shared types and constants for the two-lane cola vending scheduler.
package vend_pkg;

  localparam int NUM_LANES = 2;
  localparam int CREDIT_W  = 3;
  localparam int WAIT_W    = 8;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    DONE = 3'b100
  } arb_state_t;

  // Round-robin pick: on a tie the lane that was not served last wins.
  function automatic logic pick_lane(input logic [NUM_LANES-1:0] pending,
                                     input logic                 last);
    if (pending[0] && pending[1]) return ~last;
    else if (pending[1])          return 1'b1;
    else                          return 1'b0;
  endfunction

endpackage

// File: rtl/cola_vend_arb_if.sv
// Request/acknowledge handshake between the scheduler and the dispenser driver.
interface cola_vend_arb_if;

  logic disp_req;
  logic disp_lane;
  logic disp_ack;
  logic disp_err;

  modport master (output disp_req, output disp_lane, output disp_err, input disp_ack);
  modport slave  (input disp_req, input disp_lane, input disp_err, output disp_ack);

endinterface

// File: rtl/cola_vend_arb_lane_credit.sv
// Per-lane coin credit counter: saturates at PRICE, refunds coins into a full lane.
module lane_credit
  import vend_pkg::*;
#(
  parameter int PRICE = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                coin,
  input  logic                clr,
  output logic [CREDIT_W-1:0] credit,
  output logic                pending,
  output logic                refund
);

  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(PRICE);

  // A clear from the arbiter beats a coin arriving in the same cycle; that coin is still refunded.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      credit <= '0;
      refund <= 1'b0;
    end else begin
      refund <= coin && (credit == FULL);
      if (clr)
        credit <= '0;
      else if (coin && (credit != FULL))
        credit <= credit + CREDIT_W'(1);
    end
  end

  assign pending = (credit == FULL);

endmodule

// File: rtl/cola_vend_arb.sv
// Two-lane vending scheduler: round-robin arbiter sharing one dispenser with ack timeout.
module cola_vend_arb
  import vend_pkg::*;
#(
  parameter int PRICE   = 3,
  parameter int DISP_TO = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_LANES-1:0] pi_money,
  cola_vend_arb_if.master      disp,
  output logic [NUM_LANES-1:0] po_cola,
  output logic [NUM_LANES-1:0] po_refund,
  output logic [CREDIT_W-1:0]  credit0,
  output logic [CREDIT_W-1:0]  credit1
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DISP_TO - 1);

  arb_state_t           state_q, state_d;
  logic                 last_q, last_d;
  logic                 lane_q, lane_d;
  logic                 req_q, req_d;
  logic                 err_q, err_d;
  logic [NUM_LANES-1:0] cola_q, cola_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [NUM_LANES-1:0] clr;
  logic [NUM_LANES-1:0] pending;
  logic [NUM_LANES-1:0] refund;

  lane_credit #(.PRICE(PRICE)) u_lane0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .coin    (pi_money[0]),
    .clr     (clr[0]),
    .credit  (credit0),
    .pending (pending[0]),
    .refund  (refund[0])
  );

  lane_credit #(.PRICE(PRICE)) u_lane1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .coin    (pi_money[1]),
    .clr     (clr[1]),
    .credit  (credit1),
    .pending (pending[1]),
    .refund  (refund[1])
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      lane_q  <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cola_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      lane_q  <= lane_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cola_q  <= cola_d;
      wait_q  <= wait_d;
    end
  end

  // An ack on the timeout cycle counts as a successful vend, so it is tested first.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    lane_d  = lane_q;
    req_d   = req_q;
    err_d   = 1'b0;
    cola_d  = '0;
    wait_d  = wait_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (|pending) begin
          lane_d  = pick_lane(pending, last_q);
          req_d   = 1'b1;
          wait_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (disp.disp_ack) begin
          req_d          = 1'b0;
          cola_d[lane_q] = 1'b1;
          clr[lane_q]    = 1'b1;
          last_d         = lane_q;
          state_d        = DONE;
        end else if (wait_q == WAIT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          last_d  = lane_q;
          state_d = DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign disp.disp_req  = req_q;
  assign disp.disp_lane = lane_q;
  assign disp.disp_err  = err_q;
  assign po_cola        = cola_q;
  assign po_refund      = refund;

endmodule

// File: doc/cola_vend_arb.md
# cola_vend_arb

Two-lane vending scheduler that shares one cola dispenser between two independent coin slots. Each lane accumulates one-coin pulses into a per-lane credit; a full lane (credit == PRICE) becomes pending. A round-robin arbiter grants the dispenser to one pending lane at a time through a req/ack handshake with timeout. It sits between the coin-slot debouncers and the dispenser motor driver.

## Interface
Parameters:
- PRICE, 3, coins per cola; legal range 1..7.
- DISP_TO, 16, max cycles to wait for disp_ack; legal range 2..255.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- pi_money  input  2  bit i = one-cycle coin pulse on lane i.
- disp_ack  input  1  dispenser done pulse; only sampled in REQ.
- disp_req  output  1  level request to dispenser.
- disp_lane  output  1  lane being served; valid while disp_req = 1.
- po_cola  output  2  one-cycle pulse, bit i = lane i served.
- po_refund  output  2  one-cycle pulse, bit i = lane i coin rejected.
- disp_err  output  1  one-cycle pulse on dispenser timeout.
- credit0, credit1  output  3  current lane credit, 0..PRICE.

## Operation
- Reset values: disp_req = 0, disp_lane = 0, po_cola = 0, po_refund = 0, disp_err = 0, credits = 0, state = IDLE, rr pointer last = 1 (lane 0 wins the first tie).
- Lane credit:
  - Coin with credit < PRICE: credit + 1.
  - Coin with credit == PRICE: credit unchanged; po_refund[i] pulses next cycle.
  - Lane pending ⇔ credit == PRICE.
- FSM states and transitions:
  - IDLE:
    - No pending lane: stay.
    - One pending lane: grant it.
    - Both pending: grant the lane ≠ last.
    - On grant: latch disp_lane, set disp_req = 1, clear the wait counter, go to REQ.
  - REQ:
    - disp_req held at 1; wait counter increments each cycle.
    - disp_ack = 1: disp_req ← 0, po_cola[disp_lane] ← 1, credit[disp_lane] ← 0, last ← disp_lane, go to DONE.
    - Else, counter == DISP_TO−1: disp_req ← 0, disp_err ← 1, credit kept (lane stays pending), last ← disp_lane, go to DONE.
  - DONE: all pulses return to 0; unconditionally go to IDLE.
- Simultaneous events:
  - Coin and ack on the served lane in the same cycle: coin is refunded (lane was full) and credit clears to 0.
  - Coins on both lanes in the same cycle: handled independently.
  - disp_ack outside REQ: ignored.
  - Ack on the timeout cycle: ack wins.
- Reset mid-operation (any state): everything returns to reset values next edge; disp_req drops; no po_cola or disp_err is issued for the aborted grant.
- Width rules:
  - Credit is 3 bits and saturates at PRICE; it never wraps.
  - Wait counter is 8 bits; its compare is against DISP_TO−1.

## Timing
- Coin at edge t → credit visible after edge t+1.
- Credit reaches PRICE after edge t → disp_req high after edge t+1 (grant in IDLE).
- disp_ack sampled at edge a → po_cola pulse and disp_req low after edge a; FSM in IDLE after a+1; earliest next disp_req after a+2.
- Timeout: disp_req high for exactly DISP_TO cycles, then disp_err pulses for 1 cycle.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package vend_pkg holds:
  - State encoding, one-hot 3-bit: IDLE = 3'b001, REQ = 3'b010, DONE = 3'b100.
  - NUM_LANES = 2.
  - Credit and wait-counter width constants.
- Sub-module lane_credit, instantiated twice. It holds the per-lane credit counter, the pending flag and the refund pulse. It takes a clear input from the arbiter, and clear has priority over increment.
- Top level holds the arbiter FSM, rr pointer, wait counter and output registers.

## Test plan
- Three coins on lane 0, ack 2 cycles after disp_req → disp_lane = 0; po_cola = 2'b01 for 1 cycle; credit0 = 0; no refund, no error.
- Both lanes reach 3 on the same edge; ack each request after 1 cycle → lane 0 served first, then lane 1; two po_cola pulses, 2'b01 then 2'b10.
- Fourth coin on lane 1 while it is pending → po_refund = 2'b10 for 1 cycle; credit1 stays 3.
- Lane 0 full, no ack → disp_req high for 16 cycles; disp_err pulses; credit0 = 3; lane 0 re-requested 2 cycles later.
- Lane 0 full with an ack pending; lane 1 fills during lane 0's service → after DONE, lane 1 is granted (rr); lane 0 is not re-served.
- sys_rst asserted mid-REQ → next edge: disp_req = 0, credits = 0, no po_cola or disp_err; normal purchase works afterwards.
